pc_fetch_unit: RTL and testbench

Instruction-fetch stage of the RV32IM pipeline: owns the program counter, drives the instruction-memory read port with busy-wait handshake, and loads the IF/ID pipeline register. It consumes the branch/jump decision from the EX-stage branch controller (`B_PC`, `BRANCH_SEL`) and the load-use stall from the hazard unit. It redirects the PC, squashes wrong-path fetches, and buffers one fetched instruction across stalls.

---
 rtl/pc_fetch_unit_if.sv | 22 ++
 rtl/pc_fetch_unit.sv | 153 +++++++++++++++
 tb/tb_pc_fetch_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory read port between the fetch stage and imem.
// Busy-wait handshake: data is valid when READ=1 and BUSYWAIT=0.
interface pc_fetch_unit_if;
  logic        IMEM_READ;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_INSTR;
  logic        IMEM_BUSYWAIT;

  modport master (
    output IMEM_READ,
    output IMEM_ADDR,
    input  IMEM_INSTR,
    input  IMEM_BUSYWAIT
  );

  modport slave (
    input  IMEM_READ,
    input  IMEM_ADDR,
    output IMEM_INSTR,
    output IMEM_BUSYWAIT
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// RV32IM instruction-fetch stage: PC, imem read port, IF/ID register.
// Handles redirects, busy-wait squash and one-entry stall buffer.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [31:0] B_PC,
  input  logic        BRANCH_SEL,
  input  logic        HAZ_STALL,
  pc_fetch_unit_if.master imem,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_PC4,
  output logic [31:0] IF_INSTR,
  output logic        IF_VALID,
  output logic        FLUSH
);

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    HOLD,
    REDIR_WAIT
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_redir_pc;
  logic [31:0] r_buf_pc;
  logic [31:0] r_buf_instr;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_pc4;
  logic [31:0] r_if_instr;
  logic        r_if_valid;

  logic [31:0] w_tgt;
  logic [31:0] w_pc4;
  logic        w_busy;
  logic        w_ld_bub;
  logic        w_ld_mem;
  logic        w_ld_buf;

  assign w_tgt  = B_PC & ~32'h3;
  assign w_pc4  = r_pc + 32'd4;
  assign w_busy = imem.IMEM_BUSYWAIT;

  assign imem.IMEM_READ = (r_state == FETCH) ||
                          (r_state == REDIR_WAIT);
  assign imem.IMEM_ADDR = r_pc;
  assign FLUSH          = BRANCH_SEL;

  assign IF_PC    = r_if_pc;
  assign IF_PC4   = r_if_pc4;
  assign IF_INSTR = r_if_instr;
  assign IF_VALID = r_if_valid;

  // IF/ID load select; no select means IF/ID holds.
  always_comb begin
    w_ld_bub = 1'b0;
    w_ld_mem = 1'b0;
    w_ld_buf = 1'b0;
    unique case (r_state)
      BOOT: ;
      FETCH: begin
        if (BRANCH_SEL)     w_ld_bub = 1'b1;
        else if (HAZ_STALL) w_ld_bub = 1'b0;
        else if (w_busy)    w_ld_bub = 1'b1;
        else                w_ld_mem = 1'b1;
      end
      HOLD: begin
        if (BRANCH_SEL)      w_ld_bub = 1'b1;
        else if (!HAZ_STALL) w_ld_buf = 1'b1;
      end
      REDIR_WAIT: begin
        w_ld_bub = BRANCH_SEL || !HAZ_STALL;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_if_pc    <= 32'h0;
      r_if_pc4   <= 32'h0;
      r_if_instr <= NOP_INSTR;
      r_if_valid <= 1'b0;
    end else if (w_ld_bub) begin
      r_if_pc    <= r_pc;
      r_if_pc4   <= w_pc4;
      r_if_instr <= NOP_INSTR;
      r_if_valid <= 1'b0;
    end else if (w_ld_mem) begin
      r_if_pc    <= r_pc;
      r_if_pc4   <= w_pc4;
      r_if_instr <= imem.IMEM_INSTR;
      r_if_valid <= 1'b1;
    end else if (w_ld_buf) begin
      r_if_pc    <= r_buf_pc;
      r_if_pc4   <= r_buf_pc + 32'd4;
      r_if_instr <= r_buf_instr;
      r_if_valid <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state     <= BOOT;
      r_pc        <= RESET_VECTOR;
      r_redir_pc  <= RESET_VECTOR;
      r_buf_pc    <= 32'h0;
      r_buf_instr <= NOP_INSTR;
    end else begin
      unique case (r_state)
        BOOT: r_state <= FETCH;
        FETCH: begin
          if (w_busy) begin
            // In-flight access cannot be aborted; park target.
            if (BRANCH_SEL) begin
              r_redir_pc <= w_tgt;
              r_state    <= REDIR_WAIT;
            end
          end else if (BRANCH_SEL) begin
            r_pc <= w_tgt;
          end else if (HAZ_STALL) begin
            r_buf_pc    <= r_pc;
            r_buf_instr <= imem.IMEM_INSTR;
            r_pc        <= w_pc4;
            r_state     <= HOLD;
          end else begin
            r_pc <= w_pc4;
          end
        end
        HOLD: begin
          if (BRANCH_SEL) begin
            r_pc    <= w_tgt;
            r_state <= FETCH;
          end else if (!HAZ_STALL) begin
            r_state <= FETCH;
          end
        end
        REDIR_WAIT: begin
          if (!w_busy) begin
            r_pc    <= BRANCH_SEL ? w_tgt : r_redir_pc;
            r_state <= FETCH;
          end else if (BRANCH_SEL) begin
            r_redir_pc <= w_tgt;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: per-cycle vector table, comb checks
// before the edge, IF/ID checks via a scoreboard queue after it.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] b_pc;
  logic        br;
  logic        st;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        flush;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pc_fetch_unit_if imem ();

  function automatic logic [31:0] mw(input logic [31:0] a);
    return a ^ 32'hC0DE_0003;
  endfunction

  assign imem.IMEM_INSTR = mw(imem.IMEM_ADDR);

  pc_fetch_unit u_dut (
    .CLK       (clk),
    .RESET_N   (rst_n),
    .B_PC      (b_pc),
    .BRANCH_SEL(br),
    .HAZ_STALL (st),
    .imem      (imem),
    .IF_PC     (if_pc),
    .IF_PC4    (if_pc4),
    .IF_INSTR  (if_instr),
    .IF_VALID  (if_valid),
    .FLUSH     (flush)
  );

  typedef struct {
    logic        rst;
    logic        br;
    logic [31:0] bpc;
    logic        st;
    logic        bz;
    logic        rd;
    logic [31:0] addr;
    logic        v;
    logic [31:0] pc;
    logic        pcz;
  } vec_t;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        pcz;
    int          id;
  } exp_t;

  vec_t vt[$];
  exp_t sbq[$];

  function automatic vec_t mk(
    input logic rst, input logic br_i, input logic [31:0] bpc,
    input logic st_i, input logic bz, input logic rd,
    input logic [31:0] addr, input logic v,
    input logic [31:0] pc, input logic pcz);
    vec_t x;
    x.rst = rst; x.br = br_i; x.bpc = bpc; x.st = st_i;
    x.bz = bz; x.rd = rd; x.addr = addr; x.v = v;
    x.pc = pc; x.pcz = pcz;
    return x;
  endfunction

  task automatic chk(input string nm, input int id,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h required %h",
               nm, id, act, req);
    end
  endtask

  initial begin
    exp_t e;
    vec_t v;
    rst_n = 1'b0;
    br    = 1'b0;
    st    = 1'b0;
    b_pc  = 32'h0;
    imem.IMEM_BUSYWAIT = 1'b0;

    // rst br bpc st bz | rd addr | v pc pcz
    vt.push_back(mk(1,0,32'h0,0,0, 0,32'h0,   0,32'h0,0));
    vt.push_back(mk(1,0,32'h0,0,0, 1,32'h0,   1,32'h0,0));
    vt.push_back(mk(1,0,32'h0,0,0, 1,32'h4,   1,32'h4,0));
    vt.push_back(mk(1,0,32'h0,0,0, 1,32'h8,   1,32'h8,0));
    vt.push_back(mk(1,0,32'h0,0,0, 1,32'hC,   1,32'hC,0));
    vt.push_back(mk(1,1,32'h100,0,0, 1,32'h10, 0,32'h0,0));
    vt.push_back(mk(1,0,32'h0,0,0, 1,32'h100, 1,32'h100,0));
    vt.push_back(mk(1,1,32'h23,0,0, 1,32'h104, 0,32'h0,0));
    vt.push_back(mk(1,0,32'h0,0,1, 1,32'h20,  0,32'h0,0));
    vt.push_back(mk(1,0,32'h0,0,1, 1,32'h20,  0,32'h0,0));
    vt.push_back(mk(1,0,32'h0,0,1, 1,32'h20,  0,32'h0,0));
    vt.push_back(mk(1,0,32'h0,0,0, 1,32'h20,  1,32'h20,0));
    vt.push_back(mk(1,0,32'h0,1,0, 1,32'h24,  1,32'h20,0));
    vt.push_back(mk(1,0,32'h0,1,0, 0,32'h28,  1,32'h20,0));
    vt.push_back(mk(1,0,32'h0,0,0, 0,32'h28,  1,32'h24,0));
    vt.push_back(mk(1,0,32'h0,0,0, 1,32'h28,  1,32'h28,0));
    vt.push_back(mk(1,0,32'h0,1,1, 1,32'h2C,  1,32'h28,0));
    vt.push_back(mk(1,0,32'h0,0,0, 1,32'h2C,  1,32'h2C,0));
    vt.push_back(mk(1,1,32'h40,0,0, 1,32'h30, 0,32'h0,0));
    vt.push_back(mk(1,1,32'h200,0,1, 1,32'h40, 0,32'h0,0));
    vt.push_back(mk(1,0,32'h0,0,1, 1,32'h40,  0,32'h0,0));
    vt.push_back(mk(1,0,32'h0,0,1, 1,32'h40,  0,32'h0,0));
    vt.push_back(mk(1,0,32'h0,0,0, 1,32'h40,  0,32'h0,0));
    vt.push_back(mk(1,0,32'h0,0,0, 1,32'h200, 1,32'h200,0));
    vt.push_back(mk(1,1,32'h300,0,1, 1,32'h204, 0,32'h0,0));
    vt.push_back(mk(1,1,32'h401,0,1, 1,32'h204, 0,32'h0,0));
    vt.push_back(mk(1,0,32'h0,1,1, 1,32'h204, 0,32'h0,0));
    vt.push_back(mk(1,0,32'h0,0,0, 1,32'h204, 0,32'h0,0));
    vt.push_back(mk(1,0,32'h0,0,0, 1,32'h400, 1,32'h400,0));
    vt.push_back(mk(1,0,32'h0,1,0, 1,32'h404, 1,32'h400,0));
    vt.push_back(mk(1,1,32'h500,0,0, 0,32'h408, 0,32'h0,0));
    vt.push_back(mk(1,0,32'h0,0,0, 1,32'h500, 1,32'h500,0));
    vt.push_back(mk(1,1,32'hFFFF_FFFC,0,0, 1,32'h504, 0,32'h0,0));
    vt.push_back(mk(1,0,32'h0,0,0, 1,32'hFFFF_FFFC, 1,32'hFFFF_FFFC,0));
    vt.push_back(mk(1,0,32'h0,0,0, 1,32'h0,   1,32'h0,0));
    vt.push_back(mk(1,1,32'h80,0,1, 1,32'h4,  0,32'h0,0));
    vt.push_back(mk(0,0,32'h0,0,0, 1,32'h4,   0,32'h0,1));
    vt.push_back(mk(1,0,32'h0,0,0, 0,32'h0,   0,32'h0,1));
    vt.push_back(mk(1,1,32'h103,0,0, 1,32'h0, 0,32'h0,0));
    vt.push_back(mk(1,0,32'h0,0,0, 1,32'h100, 1,32'h100,0));

    // Reset state from power-up
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_pc",    -1, if_pc,    32'h0);
    chk("rst_if_pc4",   -1, if_pc4,   32'h0);
    chk("rst_if_instr", -1, if_instr, 32'h13);
    chk("rst_if_valid", -1, {31'h0, if_valid}, 32'h0);
    chk("rst_imem_read",-1, {31'h0, imem.IMEM_READ}, 32'h0);
    chk("rst_imem_addr",-1, imem.IMEM_ADDR, 32'h0);

    for (int i = 0; i < vt.size(); i++) begin
      v = vt[i];
      @(negedge clk);
      rst_n = v.rst;
      br    = v.br;
      b_pc  = v.bpc;
      st    = v.st;
      imem.IMEM_BUSYWAIT = v.bz;
      #1;
      chk("imem_read", i, {31'h0, imem.IMEM_READ}, {31'h0, v.rd});
      chk("imem_addr", i, imem.IMEM_ADDR, v.addr);
      chk("flush",     i, {31'h0, flush}, {31'h0, v.br});
      e.v = v.v; e.pc = v.pc; e.pcz = v.pcz; e.id = i;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard_empty vec %0d: got 0 required 1", i);
      end else begin
        e = sbq.pop_front();
        chk("if_valid", e.id, {31'h0, if_valid}, {31'h0, e.v});
        chk("if_instr", e.id, if_instr,
            e.v ? mw(e.pc) : 32'h13);
        if (e.v) begin
          chk("if_pc",  e.id, if_pc,  e.pc);
          chk("if_pc4", e.id, if_pc4, e.pc + 32'd4);
        end
        if (e.pcz) begin
          chk("rst_pc",  e.id, if_pc,  32'h0);
          chk("rst_pc4", e.id, if_pc4, 32'h0);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
